display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_scan_controller.sv | 160 ++++++++++++++++
 tb/tb_display_scan_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
//
// Time-multiplexes a 4-character message onto a 4-digit display. The display
// shares one character decoder between the digits. Each digit is lit for DIV
// cycles. Between digits, all digits are dark for GAP cycles so that segments
// do not ghost onto the next digit. A new message is double-buffered: it is
// held in a pending register and copied into the displayed (shadow) register
// only at a frame boundary, or while the scanner is idle. Every frame therefore
// shows characters from a single message.
//
// Ports
//   clk         : single clock, rising edge
//   rst         : synchronous active-high reset
//   enable      : 1 = scan digits, 0 = blank display
//   load_valid  : a new 4-character message is offered on load_chars
//   load_chars  : four 4-bit codes, bits [4i+3:4i] for digit i (digit 0 rightmost)
//   load_ready  : the pending buffer is free, so a message can be accepted
//   char_sel    : character code for the shared decoder
//   digit_en_n  : active-low digit enables, bit i drives digit i
//   frame_done  : one-cycle pulse in the last dead-time cycle of a frame
// -----------------------------------------------------------------------------
module display_scan_controller #(
   parameter int unsigned DIV = 50000,  // digit on-time in cycles, 1 .. 2^20-1
   parameter int unsigned GAP = 2       // inter-digit dead-time in cycles, 1 .. 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        load_valid,
   input  logic [15:0] load_chars,
   output logic        load_ready,
   output logic [3:0]  char_sel,
   output logic [3:0]  digit_en_n,
   output logic        frame_done
);

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_e;

   localparam logic [19:0] DIV_M1 = 20'(DIV - 1);
   localparam logic [19:0] GAP_M1 = 20'(GAP - 1);

   state_e      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [19:0] cnt_q, cnt_d;
   logic [15:0] shadow_q, shadow_d;
   logic [15:0] pending_q, pending_d;
   logic        pend_flag_q, pend_flag_d;
   logic [3:0]  char_sel_q, char_sel_d;
   logic [3:0]  digit_en_n_q, digit_en_n_d;
   logic        frame_done_q, frame_done_d;
   logic        load_ready_q, load_ready_d;

   always_comb begin
      // NOTE: every _d signal gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      shadow_d    = shadow_q;
      pending_d   = pending_q;
      pend_flag_d = pend_flag_q;

      // Capture and transfer are mutually exclusive. A capture needs an empty
      // buffer, and a transfer needs a full one. A message captured on the
      // frame_done cycle therefore waits for the next boundary.
      if (load_valid && !pend_flag_q) begin
         pending_d   = load_chars;
         pend_flag_d = 1'b1;
      end else if (pend_flag_q && (state_q == S_IDLE || frame_done_q)) begin
         shadow_d    = pending_q;
         pend_flag_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_ON;
               idx_d   = 2'd0;
               cnt_d   = 20'd0;
            end
         end
         S_ON: begin
            if (!enable) begin
               state_d = S_IDLE;
               idx_d   = 2'd0;
               cnt_d   = 20'd0;
            end else if (cnt_q == DIV_M1) begin
               state_d = S_OFF;
               cnt_d   = 20'd0;
            end else begin
               cnt_d = cnt_q + 20'd1;
            end
         end
         S_OFF: begin
            // At the end of a frame, enable only chooses between a new frame
            // and idling. The frame_done pulse has already been issued.
            if (cnt_q == GAP_M1 && idx_q == 2'd3) begin
               state_d = enable ? S_ON : S_IDLE;
               idx_d   = 2'd0;
               cnt_d   = 20'd0;
            end else if (!enable) begin
               state_d = S_IDLE;
               idx_d   = 2'd0;
               cnt_d   = 20'd0;
            end else if (cnt_q == GAP_M1) begin
               state_d = S_ON;
               idx_d   = idx_q + 2'd1;
               cnt_d   = 20'd0;
            end else begin
               cnt_d = cnt_q + 20'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            cnt_d   = 20'd0;
         end
      endcase

      // The outputs are decoded from the next state, so each registered output
      // lines up with the state it describes.
      digit_en_n_d = (state_d == S_ON) ? ~(4'b0001 << idx_d) : 4'b1111;
      char_sel_d   = (state_d == S_ON) ? shadow_d[{idx_d, 2'b00} +: 4] : char_sel_q;
      frame_done_d = (state_d == S_OFF) && (cnt_d == GAP_M1) && (idx_d == 2'd3);
      load_ready_d = ~pend_flag_d;
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= 2'd0;
         cnt_q        <= 20'd0;
         shadow_q     <= 16'hFFFF;
         pending_q    <= 16'hFFFF;
         pend_flag_q  <= 1'b0;
         char_sel_q   <= 4'hF;
         digit_en_n_q <= 4'b1111;
         frame_done_q <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         pend_flag_q  <= pend_flag_d;
         char_sel_q   <= char_sel_d;
         digit_en_n_q <= digit_en_n_d;
         frame_done_q <= frame_done_d;
         load_ready_q <= load_ready_d;
      end
   end

   assign load_ready = load_ready_q;
   assign char_sel   = char_sel_q;
   assign digit_en_n = digit_en_n_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_display_scan_controller
//
// Self-checking bench for display_scan_controller with DIV=4 and GAP=2.
// The reference model tracks the time position within a frame as one integer.
// It derives the lit digit and the frame_done pulse from that position using
// division and modulo. A vector table covers reset and the first frames.
// Hand-written sequences cover the multi-cycle corner cases, and a randomised
// run follows them.
// -----------------------------------------------------------------------------
module tb_display_scan_controller;

   localparam int DIV    = 4;
   localparam int GAP    = 2;
   localparam int SLOT   = DIV + GAP;
   localparam int PERIOD = 4 * SLOT;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        load_valid;
   logic [15:0] load_chars;
   logic        load_ready;
   logic [3:0]  char_sel;
   logic [3:0]  digit_en_n;
   logic        frame_done;

   always #5 clk = ~clk;

   display_scan_controller #(.DIV(DIV), .GAP(GAP)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load_valid (load_valid),
      .load_chars (load_chars),
      .load_ready (load_ready),
      .char_sel   (char_sel),
      .digit_en_n (digit_en_n),
      .frame_done (frame_done)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   bit          m_active = 1'b0;
   int          m_t      = 0;     // cycle position within the current frame
   logic [15:0] m_shadow = 16'hFFFF;
   logic [15:0] m_pending = 16'hFFFF;
   bit          m_pflag  = 1'b0;
   logic [3:0]  m_char   = 4'hF;
   logic [3:0]  m_en_n   = 4'hF;
   bit          m_fd     = 1'b0;

   task automatic model_step(input bit r, input bit en, input bit lv, input logic [15:0] ch);
      int digit;
      if (r) begin
         m_active  = 1'b0;
         m_t       = 0;
         m_shadow  = 16'hFFFF;
         m_pending = 16'hFFFF;
         m_pflag   = 1'b0;
         m_char    = 4'hF;
         m_en_n    = 4'hF;
         m_fd      = 1'b0;
      end else begin
         if (lv && !m_pflag) begin
            m_pending = ch;
            m_pflag   = 1'b1;
         end else if (m_pflag && (!m_active || m_fd)) begin
            m_shadow = m_pending;
            m_pflag  = 1'b0;
         end
         if (!m_active) begin
            if (en) begin
               m_active = 1'b1;
               m_t      = 0;
            end
         end else if (m_t == PERIOD - 1) begin
            m_t      = 0;
            m_active = en;
         end else if (!en) begin
            m_active = 1'b0;
            m_t      = 0;
         end else begin
            m_t++;
         end
         if (m_active && (m_t % SLOT) < DIV) begin
            digit  = m_t / SLOT;
            m_en_n = ~(4'b0001 << digit);
            m_char = m_shadow[4*digit +: 4];
         end else begin
            m_en_n = 4'hF;
         end
         m_fd = m_active && (m_t == PERIOD - 1);
      end
   endtask

   // One clock: drive on the falling edge, then advance the model at the
   // rising edge and compare one time unit later.
   task automatic tick(input bit r, input bit en, input bit lv, input logic [15:0] ch);
      @(negedge clk);
      rst        = r;
      enable     = en;
      load_valid = lv;
      load_chars = ch;
      @(posedge clk);
      model_step(r, en, lv, ch);
      #1;
      cyc++;
      check($sformatf("cyc%0d model digit_en_n", cyc), 16'(digit_en_n), 16'(m_en_n));
      check($sformatf("cyc%0d model char_sel", cyc),   16'(char_sel),   16'(m_char));
      check($sformatf("cyc%0d model frame_done", cyc), 16'(frame_done), 16'(m_fd));
      check($sformatf("cyc%0d model load_ready", cyc), 16'(load_ready), 16'(!m_pflag));
   endtask

   // Runs one full frame from its first cycle and checks the shown message
   // against constants. Optionally offers a load on tick lv_at.
   task automatic frame_check(input string tag, input logic [15:0] exp, input int lv_at,
                              input logic [15:0] ld);
      int         d;
      bit         on;
      logic [3:0] want_en;
      for (int i = 0; i < PERIOD; i++) begin
         d       = i / SLOT;
         on      = (i % SLOT) < DIV;
         want_en = on ? ~(4'b0001 << d) : 4'hF;
         tick(1'b0, 1'b1, i == lv_at, ld);
         check($sformatf("%s t%0d digit_en_n", tag, i), 16'(digit_en_n), 16'(want_en));
         if (on) check($sformatf("%s t%0d char_sel", tag, i), 16'(char_sel), 16'(exp[4*d +: 4]));
         check($sformatf("%s t%0d frame_done", tag, i), 16'(frame_done), 16'(i == PERIOD - 1));
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          rst;
      bit          en;
      bit          lv;
      logic [15:0] chars;
      logic [3:0]  en_n;
      logic [3:0]  ch;
      bit          rdy;
      bit          fd;
   } vec_t;

   vec_t       vecs[$];
   logic [3:0] en_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [3:0] msg_ch [4] = '{4'h0, 4'h1, 4'h3, 4'h8};

   task automatic add(input bit r, input bit en, input bit lv, input logic [15:0] chars,
                      input logic [3:0] en_n, input logic [3:0] ch, input bit rdy, input bit fd);
      vec_t v;
      v.rst = r; v.en = en; v.lv = lv; v.chars = chars;
      v.en_n = en_n; v.ch = ch; v.rdy = rdy; v.fd = fd;
      vecs.push_back(v);
   endtask

   initial begin
      bit en_r;
      rst = 1'b1; enable = 1'b0; load_valid = 1'b0; load_chars = 16'h0;

      // Reset, idle, load while idle, then two full frames of 8310.
      for (int i = 0; i < 2; i++)  add(1, 0, 0, 16'h0, 4'hF, 4'hF, 1, 0);
      for (int i = 0; i < 10; i++) add(0, 0, 0, 16'h0, 4'hF, 4'hF, 1, 0);
      add(0, 0, 1, 16'h8310, 4'hF, 4'hF, 0, 0);
      add(0, 0, 0, 16'h0,    4'hF, 4'hF, 1, 0);
      for (int f = 0; f < 2; f++)
         for (int d = 0; d < 4; d++)
            for (int k = 0; k < SLOT; k++)
               add(0, 1, 0, 16'h0, (k < DIV) ? en_pat[d] : 4'hF, msg_ch[d], 1,
                   (d == 3) && (k == SLOT - 1));

      foreach (vecs[i]) begin
         tick(vecs[i].rst, vecs[i].en, vecs[i].lv, vecs[i].chars);
         check($sformatf("vec%0d digit_en_n", i), 16'(digit_en_n), 16'(vecs[i].en_n));
         check($sformatf("vec%0d char_sel", i),   16'(char_sel),   16'(vecs[i].ch));
         check($sformatf("vec%0d load_ready", i), 16'(load_ready), 16'(vecs[i].rdy));
         check($sformatf("vec%0d frame_done", i), 16'(frame_done), 16'(vecs[i].fd));
      end

      // Mid-frame load: the current frame keeps 8310, and the next frame shows 2222.
      frame_check("midload", 16'h8310, 8, 16'h2222);
      check("midload ready held to boundary", 16'(load_ready), 16'h0);
      frame_check("after_midload", 16'h2222, -1, 16'h0);

      // Load on the frame_done cycle: one more frame of old content, then 5555.
      frame_check("boundary_load", 16'h2222, 0, 16'h5555);
      frame_check("after_boundary", 16'h5555, -1, 16'h0);

      // Disable while digit 2 is lit: the display blanks without frame_done.
      for (int i = 0; i < 14; i++) tick(1'b0, 1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 1'b0, 16'h0);
         check($sformatf("disable c%0d digit_en_n", i), 16'(digit_en_n), 16'hF);
         check($sformatf("disable c%0d frame_done", i), 16'(frame_done), 16'h0);
         check($sformatf("disable c%0d char_sel held", i), 16'(char_sel), 16'h5);
      end
      frame_check("reenable", 16'h5555, -1, 16'h0);

      // Reset during OFF with a load pending: the pending message is discarded.
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, i == 1, 16'h1234);
      check("pre-reset load_ready", 16'(load_ready), 16'h0);
      tick(1'b1, 1'b1, 1'b0, 16'h0);
      check("reset digit_en_n", 16'(digit_en_n), 16'hF);
      check("reset char_sel",   16'(char_sel),   16'hF);
      check("reset frame_done", 16'(frame_done), 16'h0);
      check("reset load_ready", 16'(load_ready), 16'h1);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0, 1'b0, 16'h0);
         check($sformatf("post-reset idle c%0d load_ready", i), 16'(load_ready), 16'h1);
      end
      frame_check("post_reset", 16'hFFFF, -1, 16'h0);

      // Randomised run against the model.
      en_r = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) en_r = ~en_r;
         tick($urandom_range(0, 299) == 0, en_r, $urandom_range(0, 7) == 0, 16'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
